ram_arbiter_rr: RTL
===================

# ram_arbiter_rr

Parametrised N-master arbiter for the simple dual-port pulse-width RAM: independent round-robin arbitration of the write port (A) and the read port (B) among N_MASTERS requesters (master 0 = DMA, others = custom logic channels). It replaces the fixed two-way DMA/custom mux with a request/grant handshake, registered RAM strobes and tagged read-data return. It sits between the masters and RAM_wrapper in the PCIe DMA design.

## Interface
- N_MASTERS, 2, number of requesters (2..8)
- W_ADDR, 12, RAM address width
- W_DATA, 128, RAM data width
- RD_LATENCY, 2, RAM read latency in cycles, from ram_rd_en to valid ram_rd_data (1..4)

- clk_in  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- m_wr_req  in  N_MASTERS  per-master write request
- m_wr_addr  in  N_MASTERS*W_ADDR  flattened write addresses, master i at [i*W_ADDR +: W_ADDR]
- m_wr_data  in  N_MASTERS*W_DATA  flattened write data
- m_wr_gnt  out  N_MASTERS  one-hot write grant
- m_rd_req  in  N_MASTERS  per-master read request
- m_rd_addr  in  N_MASTERS*W_ADDR  flattened read addresses
- m_rd_gnt  out  N_MASTERS  one-hot read grant
- m_rd_valid  out  N_MASTERS  one-hot read-data strobe
- m_rd_data  out  W_DATA  read data, shared by all masters
- ram_wr_en  out  1  RAM port A write enable
- ram_wr_addr  out  W_ADDR  RAM port A address
- ram_wr_data  out  W_DATA  RAM port A data
- ram_rd_en  out  1  RAM port B read enable
- ram_rd_addr  out  W_ADDR  RAM port B address
- ram_rd_data  in  W_DATA  RAM port B data

## Operation
- Write and read arbitration are independent; one write and one read may issue in the same cycle.
- Grants are combinational from current requests and the round-robin pointer. At most one bit set per grant vector; all zero when there are no requests.
- A transfer is accepted on a rising edge where req[i] & gnt[i]. A master holds its addr/data stable while req is high and gnt is low. A master may drop req without a grant (no penalty).
- Round-robin: the search starts at ptr and wraps modulo N_MASTERS. After an accepted transfer by master i, ptr <= (i+1) mod N_MASTERS. Without an accepted transfer, ptr is unchanged. Write and read have separate pointers.
- Back-to-back: one master requesting continuously is granted every cycle (100% throughput). With all requesters active, grants rotate 0,1,…,N-1,0.
- Read return: each accepted read pushes {valid, master id} into a RD_LATENCY+1 stage shift register. m_rd_valid[id] is asserted when the entry exits, and m_rd_data = ram_rd_data in that cycle. Returns are in order, one per cycle at most.
- No hazard handling: a same-cycle read and write to the same address returns the RAM's old-data behaviour. Masters are responsible for ordering.
- Reset mid-operation: pipeline entries are discarded, no m_rd_valid is issued for them, and pointers return to 0.

## Timing
- Reset values: m_wr_gnt=0, m_rd_gnt=0 (no requests are honoured during reset), m_rd_valid=0, m_rd_data=0, ram_wr_en=0, ram_rd_en=0, ram_wr_addr=0, ram_rd_addr=0, ram_wr_data=0, ptr_wr=ptr_rd=0.
- Write: accepted at edge T; ram_wr_en/addr/data are registered and high in cycle T+1 for exactly one cycle per transfer.
- Read: accepted at edge T; ram_rd_en/addr in cycle T+1; m_rd_valid/m_rd_data in cycle T+1+RD_LATENCY, for one cycle. Total request-to-data latency is RD_LATENCY+1.
- m_rd_data is registered and holds its last value when m_rd_valid=0.
- Outputs on an idle cycle: ram_*_en=0; addr/data hold their previous values.

## Configuration
- ARB_MASTER0_PRIORITY_EN defined: master 0 (DMA) has strict priority on both ports. When m_*_req[0]=1 it is granted regardless of ptr, and ptr is not advanced by its grants. Masters 1..N-1 round-robin among themselves when master 0 is idle.
- Not defined: pure round-robin over all masters, as described above.

## Structure
- Package ram_arb_pkg: localparam helper for ID_W = $clog2(N_MASTERS) (minimum 1), the read-tag struct {valid, id}, and reset constants.
- Sub-module rr_arbiter (parameter N): req, accept, grant, and ptr update with the priority macro honoured. It is instantiated twice, once for write and once for read. The top level holds the muxes, the registered RAM strobes and the read-tag pipeline.

## Test plan
- Reset then a single write by master 0, addr 12'd3, data 128'h0dac_0fa0_1194_1388 -> m_wr_gnt=2'b01 in the same cycle; ram_wr_en=1, addr 3 and that data one cycle later; a read by master 1 of addr 3 -> m_rd_valid=2'b10 with that data RD_LATENCY+1 cycles after acceptance.
- N_MASTERS=4, all write requests held for 8 cycles -> grant order 0,1,2,3,0,1,2,3 and 8 ram_wr_en pulses with matching addresses.
- Interleaved reads from masters 2 and 0 on consecutive cycles, RD_LATENCY=3 -> m_rd_valid=4'b0100 then 4'b0001 on consecutive cycles, each with correct data.
- Simultaneous write (master 1) and read (master 0) in one cycle -> both granted; ram_wr_en and ram_rd_en high in the same next cycle.
- rst_n asserted asynchronously with two reads in flight -> all outputs 0 immediately; no m_rd_valid after release; first grant goes to master 0.
- ARB_MASTER0_PRIORITY_EN defined, masters 0 and 1 requesting continuously -> master 0 granted every cycle and master 1 never granted; master 1 granted on the first cycle master 0 drops req.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the round-robin RAM port arbiter.
package ram_arb_pkg;

    // Largest supported requester count and the tag id width that covers it.
    localparam int MAX_MASTERS = 8;
    localparam int MAX_ID_W    = 3;

    // Master-id width for n requesters, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One entry of the read-return pipeline: who issued the read, if anyone.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } rd_tag_t;

    localparam rd_tag_t RD_TAG_RESET = '{valid: 1'b0, id: '0};
    localparam logic    RAM_EN_RESET = 1'b0;

endpackage

// File: rtl/ram_arbiter_rr_rr_arbiter.sv
// Single-port round-robin arbiter: combinational one-hot grant from the
// current requests and a rotating pointer, plus the pointer update.
// Optional feature: ARB_MASTER0_PRIORITY_EN gives master 0 strict priority;
// its grants do not move the pointer and masters 1..N-1 rotate among themselves.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N    = 2,
    parameter int ID_W = id_width(N)
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic [N-1:0]    i_req,
    output logic [N-1:0]    o_gnt,
    output logic            o_accept,
    output logic [ID_W-1:0] o_id
);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_idx;
    logic [ID_W-1:0] w_id;
    logic [N-1:0]    w_gnt;
    logic            w_found;
`ifdef ARB_MASTER0_PRIORITY_EN
    logic [ID_W-1:0] w_start;
`endif

    // Find the first requester at or after the pointer, wrapping around.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        w_gnt   = '0;
        w_id    = '0;
        w_found = 1'b0;
        w_idx   = '0;
`ifdef ARB_MASTER0_PRIORITY_EN
        w_start = (r_ptr == '0) ? ID_W'(1) : r_ptr;
        if (i_req[0]) begin
            w_gnt[0] = 1'b1;
            w_found  = 1'b1;
        end else begin
            for (int k = 0; k < N - 1; k++) begin
                w_idx = ID_W'(1 + ((int'(w_start) - 1 + k) % (N - 1)));
                if (!w_found && i_req[w_idx]) begin
                    w_gnt[w_idx] = 1'b1;
                    w_id         = w_idx;
                    w_found      = 1'b1;
                end
            end
        end
`else
        for (int k = 0; k < N; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                w_gnt[w_idx] = 1'b1;
                w_id         = w_idx;
                w_found      = 1'b1;
            end
        end
`endif
    end

    // Advance the pointer past the master that just completed a transfer.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
`ifdef ARB_MASTER0_PRIORITY_EN
        end else if (w_found && (w_id != '0)) begin
`else
        end else if (w_found) begin
`endif
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            r_ptr <= (w_id == ID_W'(N - 1)) ? '0 : w_id + ID_W'(1);
        end
    end

    // Nothing is granted while reset is held, so no transfer can be accepted.
    assign o_gnt    = w_gnt & {N{rst_n}};
    assign o_accept = w_found & rst_n;
    assign o_id     = w_id;

endmodule

// File: rtl/ram_arbiter_rr.sv
// N-master arbiter for the simple dual-port pulse-width RAM: independent
// round-robin on the write port (A) and read port (B), registered RAM strobes
// and an in-order tagged read-data return.
// Optional feature: ARB_MASTER0_PRIORITY_EN (master 0 = DMA has strict priority).
module ram_arbiter_rr
    import ram_arb_pkg::*;
#(
    parameter int N_MASTERS  = 2,
    parameter int W_ADDR     = 12,
    parameter int W_DATA     = 128,
    parameter int RD_LATENCY = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic [N_MASTERS-1:0]          m_wr_req,
    input  logic [N_MASTERS*W_ADDR-1:0]   m_wr_addr,
    input  logic [N_MASTERS*W_DATA-1:0]   m_wr_data,
    output logic [N_MASTERS-1:0]          m_wr_gnt,
    input  logic [N_MASTERS-1:0]          m_rd_req,
    input  logic [N_MASTERS*W_ADDR-1:0]   m_rd_addr,
    output logic [N_MASTERS-1:0]          m_rd_gnt,
    output logic [N_MASTERS-1:0]          m_rd_valid,
    output logic [W_DATA-1:0]             m_rd_data,
    output logic                          ram_wr_en,
    output logic [W_ADDR-1:0]             ram_wr_addr,
    output logic [W_DATA-1:0]             ram_wr_data,
    output logic                          ram_rd_en,
    output logic [W_ADDR-1:0]             ram_rd_addr,
    input  logic [W_DATA-1:0]             ram_rd_data
);

    localparam int ID_W  = id_width(N_MASTERS);
    // One stage lines the tag up with ram_rd_en, RD_LATENCY more with the RAM.
    localparam int DEPTH = RD_LATENCY + 1;

    logic            w_wr_accept;
    logic [ID_W-1:0] w_wr_id;
    logic            w_rd_accept;
    logic [ID_W-1:0] w_rd_id;
    rd_tag_t         w_tag_in;
    rd_tag_t         w_exit;

    logic              r_wr_en;
    logic [W_ADDR-1:0] r_wr_addr;
    logic [W_DATA-1:0] r_wr_data;
    logic              r_rd_en;
    logic [W_ADDR-1:0] r_rd_addr;
    logic [W_DATA-1:0] r_rd_data;
    rd_tag_t           r_tag [DEPTH];

    rr_arbiter #(.N(N_MASTERS), .ID_W(ID_W)) u_wr_arb (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .i_req    (m_wr_req),
        .o_gnt    (m_wr_gnt),
        .o_accept (w_wr_accept),
        .o_id     (w_wr_id)
    );

    rr_arbiter #(.N(N_MASTERS), .ID_W(ID_W)) u_rd_arb (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .i_req    (m_rd_req),
        .o_gnt    (m_rd_gnt),
        .o_accept (w_rd_accept),
        .o_id     (w_rd_id)
    );

    // Register the granted master's write as a one-cycle port A strobe.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= RAM_EN_RESET;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_wr_accept;
            if (w_wr_accept) begin
                r_wr_addr <= m_wr_addr[w_wr_id*W_ADDR +: W_ADDR];
                r_wr_data <= m_wr_data[w_wr_id*W_DATA +: W_DATA];
            end
        end
    end

    // Register the granted master's read as a one-cycle port B strobe.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_en   <= RAM_EN_RESET;
            r_rd_addr <= '0;
        end else begin
            r_rd_en <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_addr <= m_rd_addr[w_rd_id*W_ADDR +: W_ADDR];
            end
        end
    end

    assign w_tag_in = '{valid: w_rd_accept, id: MAX_ID_W'(w_rd_id)};

    // Carry the issuing master's id alongside the read until the RAM answers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this small tag array must be reset so in-flight reads are dropped on reset.
            for (int s = 0; s < DEPTH; s++) begin
                r_tag[s] <= RD_TAG_RESET;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int s = 1; s < DEPTH; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_exit = r_tag[DEPTH-1];

    // Remember the last returned word so the data bus holds between returns.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (w_exit.valid) begin
            r_rd_data <= ram_rd_data;
        end
    end

    // Decode the exiting tag into a one-hot strobe for its owner.
    always_comb begin
        m_rd_valid = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_rd_valid[i] = w_exit.valid && (w_exit.id == MAX_ID_W'(i));
        end
    end

    assign m_rd_data   = w_exit.valid ? ram_rd_data : r_rd_data;
    assign ram_wr_en   = r_wr_en;
    assign ram_wr_addr = r_wr_addr;
    assign ram_wr_data = r_wr_data;
    assign ram_rd_en   = r_rd_en;
    assign ram_rd_addr = r_rd_addr;

endmodule
